regbank_sequencer: RTL and testbench
====================================

// Module: regbank_sequencer
// PURPOSE
//  Two-requester command sequencer and arbiter in front of the 32-bit RegisterBank.
//  Accepts LOAD/SHL/SHR/READ/FLUSH commands and grants requesters round-robin.
//  Drives the bank control strobes: at most one strobe per cycle, and never shift_left and shift_right together.
//  Returns a completion response carrying read data and the last serial_out bit.
// PARAMETERS
//  DATA_W   32  bank word width
//  SEL_W    6   reg_select width
//  NUM_REGS 32  implemented bank entries; sel >= NUM_REGS is illegal
//  CNT_W    5   shift-count width (0..31 shifts)
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       asynchronous, active-low reset
//  a_valid/b_valid in  1       requester command valid
//  a_ready/b_ready out 1       command accepted this cycle (1-cycle pulse)
//  a_op/b_op      in   3       0 LOAD, 1 SHL, 2 SHR, 3 READ, 4 FLUSH, 5-7 illegal
//  a_sel/b_sel    in   SEL_W   target register
//  a_data/b_data  in   DATA_W  LOAD data
//  a_cnt/b_cnt    in   CNT_W   shift count
//  a_sin/b_sin    in   1       serial fill bit for shifts
//  rsp_valid      out  1       completion pulse, 1 cycle, no backpressure
//  rsp_id         out  1       0 = A, 1 = B
//  rsp_err        out  1       illegal op or sel out of range
//  rsp_data       out  DATA_W  READ result; 0 for other ops
//  rsp_sout       out  1       bank_serial_out sampled in the last shift cycle
//  bank_load/bank_shift_left/bank_shift_right/bank_flush  out 1  bank strobes
//  bank_oe        out  1       bank output_enable
//  bank_sel       out  SEL_W   bank reg_select
//  bank_sin       out  1       bank serial_in
//  bank_din       out  DATA_W  bank data_in
//  bank_dout      in   DATA_W  bank data_out
//  bank_sout      in   1       bank serial_out
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE; all outputs 0; RR pointer favours A.
//  Reset mid-operation drops strobes at once. The in-flight command is lost; no rsp is issued.
//  FSM: IDLE -> EXEC -> [CAPT for READ] -> RESP -> IDLE.
//  IDLE: combinational grant. With one valid, grant it. With both valid, grant the requester not granted last.
//    The granted x_ready is high this cycle (cycle T); op/sel/data/cnt/sin are latched. The RR pointer updates on grant.
//    The ready signals are 0 in every other state.
//  EXEC:
//    LOAD: bank_load=1, bank_din=data, bank_sel=sel for 1 cycle (T+1).
//    SHL/SHR: the shift strobe is high for cnt consecutive cycles (T+1..T+cnt), bank_sin=sin.
//      rsp_sout = bank_sout sampled in the final strobe cycle.
//      cnt=0: one EXEC cycle with no strobe; rsp_sout=0.
//    FLUSH: bank_flush=1 for 1 cycle. sel is ignored and never flagged as an error.
//    READ: bank_oe=1, bank_sel=sel in T+1 and T+2 (CAPT). bank_dout is registered at the end of T+2.
//    Illegal op, or sel>=NUM_REGS (except FLUSH): one EXEC cycle, no strobe, rsp_err=1.
//  RESP: rsp_valid=1 for 1 cycle; rsp_id/err/data/sout are held valid only in that cycle and are 0 otherwise.
//  Latency, accept T -> rsp_valid:
//    LOAD / FLUSH / error: T+2.  SHx with cnt=N>=1: T+N+1.  SHx with cnt=0: T+2.  READ: T+3.
//  No new grant until the cycle after RESP. Back-to-back throughput is 1 command per (latency+1) cycles.
//  bank_oe=0 outside READ. bank_sel/bank_din/bank_sin are 0 in IDLE/RESP.
//  Requesters hold valid and fields until ready. Commands are never reordered or dropped.
// TESTING
//  A LOAD sel=0 data=32'h1234_5678, then A READ sel=0 -> rsp_data=32'h1234_5678, rsp_id=0, rsp_err=0, READ rsp at T+3.
//  A and B valid in the same cycle, repeatedly -> grants alternate A,B,A,B. Both strobes are never high together.
//  SHL sel=24 cnt=4 sin=1 after LOAD 32'h8000_0001 -> exactly 4 shift_left cycles; READ returns 32'h0000_001F.
//  Illegal ops: op=6, and READ sel=40 -> rsp_err=1, no bank strobe, rsp at T+2. FLUSH sel=40 -> rsp_err=0.
//  SHR cnt=0 -> no strobe, rsp at T+2, rsp_sout=0.
//  Reset pulse during SHR cnt=10 at its 3rd strobe -> strobes drop immediately; no rsp_valid; next grant goes to A.

Source files
------------

// File: rtl/regbank_sequencer_if.sv
// Requester command/response handshakes plus the RegisterBank control bus.
// slave = sequencer view; master = the requesters and the bank it drives.
interface regbank_sequencer_if #(
   parameter int DATA_W = 32,
   parameter int SEL_W  = 6,
   parameter int CNT_W  = 5
);
   logic              a_valid;
   logic              a_ready;
   logic [2:0]        a_op;
   logic [SEL_W-1:0]  a_sel;
   logic [DATA_W-1:0] a_data;
   logic [CNT_W-1:0]  a_cnt;
   logic              a_sin;

   logic              b_valid;
   logic              b_ready;
   logic [2:0]        b_op;
   logic [SEL_W-1:0]  b_sel;
   logic [DATA_W-1:0] b_data;
   logic [CNT_W-1:0]  b_cnt;
   logic              b_sin;

   logic              rsp_valid;
   logic              rsp_id;
   logic              rsp_err;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_sout;

   logic              bank_load;
   logic              bank_shift_left;
   logic              bank_shift_right;
   logic              bank_flush;
   logic              bank_oe;
   logic [SEL_W-1:0]  bank_sel;
   logic              bank_sin;
   logic [DATA_W-1:0] bank_din;
   logic [DATA_W-1:0] bank_dout;
   logic              bank_sout;

   modport slave (
      input  a_valid, a_op, a_sel, a_data, a_cnt, a_sin,
      output a_ready,
      input  b_valid, b_op, b_sel, b_data, b_cnt, b_sin,
      output b_ready,
      output rsp_valid, rsp_id, rsp_err, rsp_data, rsp_sout,
      output bank_load, bank_shift_left, bank_shift_right, bank_flush,
      output bank_oe, bank_sel, bank_sin, bank_din,
      input  bank_dout, bank_sout
   );

   modport master (
      output a_valid, a_op, a_sel, a_data, a_cnt, a_sin,
      input  a_ready,
      output b_valid, b_op, b_sel, b_data, b_cnt, b_sin,
      input  b_ready,
      input  rsp_valid, rsp_id, rsp_err, rsp_data, rsp_sout,
      input  bank_load, bank_shift_left, bank_shift_right, bank_flush,
      input  bank_oe, bank_sel, bank_sin, bank_din,
      output bank_dout, bank_sout
   );
endinterface

// File: rtl/regbank_sequencer.sv
// Two-requester round-robin command sequencer driving RegisterBank strobes.
// Accept T -> rsp at T+2 (LOAD/FLUSH/err/cnt=0), T+cnt+1 (shift), T+3 (READ); one command in flight, ready only in IDLE.
module regbank_sequencer #(
   parameter int DATA_W   = 32,
   parameter int SEL_W    = 6,
   parameter int NUM_REGS = 32,
   parameter int CNT_W    = 5
) (
   input  logic               clk,
   input  logic               reset,
   regbank_sequencer_if.slave bus
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_CAPT = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   localparam logic [2:0] OP_LOAD  = 3'd0;
   localparam logic [2:0] OP_SHL   = 3'd1;
   localparam logic [2:0] OP_SHR   = 3'd2;
   localparam logic [2:0] OP_READ  = 3'd3;
   localparam logic [2:0] OP_FLUSH = 3'd4;

   localparam logic [SEL_W:0] SEL_LIMIT = NUM_REGS[SEL_W:0];

   logic [1:0]        state_q, state_d;
   logic              rr_q, rr_d;
   logic              id_q, id_d;
   logic [2:0]        op_q, op_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sin_q, sin_d;
   logic              err_q, err_d;
   logic              sout_q, sout_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              grant_a, grant_b;
   logic [2:0]        req_op;
   logic [SEL_W-1:0]  req_sel;
   logic [DATA_W-1:0] req_data;
   logic [CNT_W-1:0]  req_cnt;
   logic              req_sin;
   logic              req_err;
   logic              exec_ok;
   logic              shift_on;

   logic              load_s, shl_s, shr_s, flush_s, oe_s, bsin_s;
   logic [SEL_W-1:0]  bsel_s;
   logic [DATA_W-1:0] bdin_s;
   logic              resp;

   // rr_q=0 favours A; the reset term keeps ready low while reset is held.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (state_q == ST_IDLE && reset) begin
         grant_a = bus.a_valid && (!bus.b_valid || !rr_q);
         grant_b = bus.b_valid && (!bus.a_valid ||  rr_q);
      end
   end

   assign req_op   = grant_b ? bus.b_op   : bus.a_op;
   assign req_sel  = grant_b ? bus.b_sel  : bus.a_sel;
   assign req_data = grant_b ? bus.b_data : bus.a_data;
   assign req_cnt  = grant_b ? bus.b_cnt  : bus.a_cnt;
   assign req_sin  = grant_b ? bus.b_sin  : bus.a_sin;

   // FLUSH touches every entry, so its select is don't-care and never an error.
   assign req_err = (req_op > OP_FLUSH) ||
                    ((req_op != OP_FLUSH) && ({1'b0, req_sel} >= SEL_LIMIT));

   assign exec_ok  = (state_q == ST_EXEC) && !err_q;
   assign shift_on = exec_ok && ((op_q == OP_SHL) || (op_q == OP_SHR)) && (cnt_q != '0);

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      id_d    = id_q;
      op_d    = op_q;
      sel_d   = sel_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      sin_d   = sin_q;
      err_d   = err_q;
      sout_d  = sout_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_a || grant_b) begin
               id_d    = grant_b;
               rr_d    = grant_a;
               op_d    = req_op;
               sel_d   = req_sel;
               data_d  = req_data;
               cnt_d   = req_cnt;
               sin_d   = req_sin;
               err_d   = req_err;
               sout_d  = 1'b0;
               rdata_d = '0;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (exec_ok && op_q == OP_READ) begin
               state_d = ST_CAPT;
            end else if (shift_on) begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  sout_d  = bus.bank_sout;
                  state_d = ST_RESP;
               end
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_CAPT: begin
            rdata_d = bus.bank_dout;
            state_d = ST_RESP;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         rr_q    <= 1'b0;
         id_q    <= 1'b0;
         op_q    <= '0;
         sel_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         sin_q   <= 1'b0;
         err_q   <= 1'b0;
         sout_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         id_q    <= id_d;
         op_q    <= op_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         sin_q   <= sin_d;
         err_q   <= err_d;
         sout_q  <= sout_d;
         rdata_q <= rdata_d;
      end
   end

   // Strobes decode straight from state so an async reset drops them at once.
   always_comb begin
      load_s  = 1'b0;
      shl_s   = 1'b0;
      shr_s   = 1'b0;
      flush_s = 1'b0;
      oe_s    = 1'b0;
      bsin_s  = 1'b0;
      bsel_s  = '0;
      bdin_s  = '0;
      if (exec_ok) begin
         case (op_q)
            OP_LOAD: begin
               load_s = 1'b1;
               bsel_s = sel_q;
               bdin_s = data_q;
            end
            OP_SHL, OP_SHR: begin
               if (shift_on) begin
                  shl_s  = (op_q == OP_SHL);
                  shr_s  = (op_q == OP_SHR);
                  bsel_s = sel_q;
                  bsin_s = sin_q;
               end
            end
            OP_READ: begin
               oe_s   = 1'b1;
               bsel_s = sel_q;
            end
            OP_FLUSH: begin
               flush_s = 1'b1;
            end
            default: begin
               load_s = 1'b0;
            end
         endcase
      end else if (state_q == ST_CAPT) begin
         oe_s   = 1'b1;
         bsel_s = sel_q;
      end
   end

   assign resp = (state_q == ST_RESP);

   assign bus.a_ready          = grant_a;
   assign bus.b_ready          = grant_b;
   assign bus.rsp_valid        = resp;
   assign bus.rsp_id           = resp && id_q;
   assign bus.rsp_err          = resp && err_q;
   assign bus.rsp_data         = resp ? rdata_q : '0;
   assign bus.rsp_sout         = resp && sout_q;
   assign bus.bank_load        = load_s;
   assign bus.bank_shift_left  = shl_s;
   assign bus.bank_shift_right = shr_s;
   assign bus.bank_flush       = flush_s;
   assign bus.bank_oe          = oe_s;
   assign bus.bank_sel         = bsel_s;
   assign bus.bank_sin         = bsin_s;
   assign bus.bank_din         = bdin_s;

   a_one_strobe: assert property (@(posedge clk) disable iff (!reset)
      $onehot0({load_s, shl_s, shr_s, flush_s}));
   a_one_ready: assert property (@(posedge clk) disable iff (!reset)
      !(grant_a && grant_b));
endmodule

// File: tb/tb_regbank_sequencer.sv
// Directed bench for regbank_sequencer with a behavioural RegisterBank model.
module tb_regbank_sequencer;
   localparam int DATA_W = 32;
   localparam int SEL_W  = 6;
   localparam int CNT_W  = 5;

   localparam logic [2:0] OP_LOAD  = 3'd0;
   localparam logic [2:0] OP_SHL   = 3'd1;
   localparam logic [2:0] OP_SHR   = 3'd2;
   localparam logic [2:0] OP_READ  = 3'd3;
   localparam logic [2:0] OP_FLUSH = 3'd4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   int n_load = 0, n_shl = 0, n_shr = 0, n_flush = 0, n_oe = 0, n_rsp = 0;
   int n_multi = 0, n_lr = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   regbank_sequencer_if #(.DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus();

   regbank_sequencer dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus.slave)
   );

   // Bank model: serial_out is the bit about to leave the selected entry.
   logic [DATA_W-1:0] mem [32];
   always @(posedge clk) begin
      if (bus.bank_flush) begin
         for (int i = 0; i < 32; i++) mem[i] <= '0;
      end else if (bus.bank_load) begin
         mem[bus.bank_sel[4:0]] <= bus.bank_din;
      end else if (bus.bank_shift_left) begin
         mem[bus.bank_sel[4:0]] <= {mem[bus.bank_sel[4:0]][DATA_W-2:0], bus.bank_sin};
      end else if (bus.bank_shift_right) begin
         mem[bus.bank_sel[4:0]] <= {bus.bank_sin, mem[bus.bank_sel[4:0]][DATA_W-1:1]};
      end
   end
   always_comb begin
      bus.bank_dout = bus.bank_oe ? mem[bus.bank_sel[4:0]] : '0;
      bus.bank_sout = bus.bank_shift_right ? mem[bus.bank_sel[4:0]][0]
                                           : mem[bus.bank_sel[4:0]][DATA_W-1];
   end

   always @(posedge clk) begin
      n_load  += int'(bus.bank_load);
      n_shl   += int'(bus.bank_shift_left);
      n_shr   += int'(bus.bank_shift_right);
      n_flush += int'(bus.bank_flush);
      n_oe    += int'(bus.bank_oe);
      n_rsp   += int'(bus.rsp_valid);
      if (int'(bus.bank_load) + int'(bus.bank_shift_left) + int'(bus.bank_shift_right)
          + int'(bus.bank_flush) > 1) n_multi++;
      if (bus.bank_shift_left && bus.bank_shift_right) n_lr++;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1);
   end

   task automatic set_req(input bit who, input logic [2:0] op, input logic [SEL_W-1:0] sel,
                          input logic [DATA_W-1:0] data, input logic [CNT_W-1:0] cnt, input logic sin);
      if (who) begin
         bus.b_op = op; bus.b_sel = sel; bus.b_data = data; bus.b_cnt = cnt; bus.b_sin = sin;
      end else begin
         bus.a_op = op; bus.a_sel = sel; bus.a_data = data; bus.a_cnt = cnt; bus.a_sin = sin;
      end
   endtask

   // Issues one command; lat=-1 means no grant or no response within the bound.
   task automatic run_cmd(input bit who, input logic [2:0] op, input logic [SEL_W-1:0] sel,
                          input logic [DATA_W-1:0] data, input logic [CNT_W-1:0] cnt, input logic sin,
                          output int lat, output logic rid, output logic rerr,
                          output logic [DATA_W-1:0] rdata, output logic rsout);
      int t_acc;
      lat = -1; rid = 1'b0; rerr = 1'b0; rdata = '0; rsout = 1'b0; t_acc = -1;
      @(negedge clk);
      set_req(who, op, sel, data, cnt, sin);
      if (who) bus.b_valid = 1'b1; else bus.a_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (who ? bus.b_ready : bus.a_ready) begin t_acc = cyc; break; end
         @(negedge clk);
      end
      @(negedge clk);
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      if (t_acc < 0) return;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (bus.rsp_valid) begin
            lat = cyc - t_acc; rid = bus.rsp_id; rerr = bus.rsp_err;
            rdata = bus.rsp_data; rsout = bus.rsp_sout;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      bus.a_valid = 1'b1; bus.b_valid = 1'b1;
      set_req(1'b0, OP_LOAD, '0, 32'h1, '0, 1'b0);
      set_req(1'b1, OP_LOAD, '0, 32'h2, '0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      tests++; if ({bus.a_ready, bus.b_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready got %b want 00", {bus.a_ready, bus.b_ready}); end
      tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
      tests++; if ({bus.bank_load, bus.bank_shift_left, bus.bank_shift_right, bus.bank_flush, bus.bank_oe} !== 5'b0) begin
         fails++; $display("FAIL reset_strobes got %b want 00000",
            {bus.bank_load, bus.bank_shift_left, bus.bank_shift_right, bus.bank_flush, bus.bank_oe}); end
      tests++; if ({bus.bank_sel, bus.bank_din} !== '0) begin fails++; $display("FAIL reset_bus got sel=%0d din=%h want 0", bus.bank_sel, bus.bank_din); end
      bus.a_valid = 1'b0; bus.b_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_round_robin();
      logic g[4]; int gc[4]; logic r[4];
      int ng = 0, nr = 0; bit both = 0;
      for (int k = 0; k < 4; k++) begin g[k] = 1'bx; gc[k] = 0; r[k] = 1'bx; end
      @(negedge clk);
      set_req(1'b0, OP_LOAD, 6'd1, 32'h0000_00A0, '0, 1'b0);
      set_req(1'b1, OP_LOAD, 6'd2, 32'h0000_00B0, '0, 1'b0);
      bus.a_valid = 1'b1; bus.b_valid = 1'b1;
      for (int i = 0; i < 40 && !(ng == 4 && nr == 4); i++) begin
         #1;
         if (bus.a_ready && bus.b_ready) both = 1;
         if (ng < 4 && (bus.a_ready || bus.b_ready)) begin g[ng] = bus.b_ready; gc[ng] = cyc; ng++; end
         if (nr < 4 && bus.rsp_valid) begin r[nr] = bus.rsp_id; nr++; end
         @(negedge clk);
         if (ng == 4) begin bus.a_valid = 1'b0; bus.b_valid = 1'b0; end
      end
      bus.a_valid = 1'b0; bus.b_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tests++; if (g[k] !== 1'(k % 2)) begin fails++; $display("FAIL rr_grant[%0d] got %b want %0d", k, g[k], k % 2); end
         tests++; if (r[k] !== 1'(k % 2)) begin fails++; $display("FAIL rr_rsp_id[%0d] got %b want %0d", k, r[k], k % 2); end
      end
      for (int k = 1; k < 4; k++) begin
         tests++; if (gc[k] - gc[k-1] !== 3) begin fails++; $display("FAIL rr_spacing[%0d] got %0d want 3", k, gc[k] - gc[k-1]); end
      end
      tests++; if (both !== 1'b0) begin fails++; $display("FAIL rr_both_ready got %b want 0", both); end
   endtask

   task automatic test_load_read();
      int lat; logic rid, rerr, rsout; logic [DATA_W-1:0] rd;
      run_cmd(1'b0, OP_LOAD, 6'd0, 32'h1234_5678, '0, 1'b0, lat, rid, rerr, rd, rsout);
      tests++; if (lat !== 2) begin fails++; $display("FAIL load_lat got %0d want 2", lat); end
      tests++; if ({rid, rerr} !== 2'b00) begin fails++; $display("FAIL load_id_err got %b want 00", {rid, rerr}); end
      tests++; if (rd !== 32'h0) begin fails++; $display("FAIL load_data got %h want 0", rd); end
      run_cmd(1'b0, OP_READ, 6'd0, '0, '0, 1'b0, lat, rid, rerr, rd, rsout);
      tests++; if (lat !== 3) begin fails++; $display("FAIL read_lat got %0d want 3", lat); end
      tests++; if (rd !== 32'h1234_5678) begin fails++; $display("FAIL read_data got %h want 12345678", rd); end
      tests++; if ({rid, rerr} !== 2'b00) begin fails++; $display("FAIL read_id_err got %b want 00", {rid, rerr}); end
      run_cmd(1'b1, OP_READ, 6'd1, '0, '0, 1'b0, lat, rid, rerr, rd, rsout);
      tests++; if (rd !== 32'h0000_00A0) begin fails++; $display("FAIL read_b_data got %h want 000000a0", rd); end
      tests++; if (rid !== 1'b1) begin fails++; $display("FAIL read_b_id got %b want 1", rid); end
   endtask

   task automatic test_shift();
      int lat, s0; logic rid, rerr, rsout; logic [DATA_W-1:0] rd;
      run_cmd(1'b0, OP_LOAD, 6'd24, 32'h8000_0001, '0, 1'b0, lat, rid, rerr, rd, rsout);
      s0 = n_shl;
      run_cmd(1'b0, OP_SHL, 6'd24, '0, 5'd4, 1'b1, lat, rid, rerr, rd, rsout);
      tests++; if (lat !== 5) begin fails++; $display("FAIL shl_lat got %0d want 5", lat); end
      tests++; if (n_shl - s0 !== 4) begin fails++; $display("FAIL shl_strobes got %0d want 4", n_shl - s0); end
      tests++; if (rsout !== 1'b0) begin fails++; $display("FAIL shl_sout got %b want 0", rsout); end
      run_cmd(1'b0, OP_READ, 6'd24, '0, '0, 1'b0, lat, rid, rerr, rd, rsout);
      tests++; if (rd !== 32'h0000_001F) begin fails++; $display("FAIL shl_result got %h want 0000001f", rd); end
      s0 = n_shr;
      run_cmd(1'b1, OP_SHR, 6'd24, '0, 5'd1, 1'b0, lat, rid, rerr, rd, rsout);
      tests++; if (lat !== 2) begin fails++; $display("FAIL shr1_lat got %0d want 2", lat); end
      tests++; if (rsout !== 1'b1) begin fails++; $display("FAIL shr1_sout got %b want 1", rsout); end
      tests++; if (n_shr - s0 !== 1) begin fails++; $display("FAIL shr1_strobes got %0d want 1", n_shr - s0); end
      run_cmd(1'b0, OP_READ, 6'd24, '0, '0, 1'b0, lat, rid, rerr, rd, rsout);
      tests++; if (rd !== 32'h0000_000F) begin fails++; $display("FAIL shr1_result got %h want 0000000f", rd); end
   endtask

   task automatic test_shift_zero();
      int lat, s0; logic rid, rerr, rsout; logic [DATA_W-1:0] rd;
      run_cmd(1'b0, OP_LOAD, 6'd3, 32'h0000_0005, '0, 1'b0, lat, rid, rerr, rd, rsout);
      s0 = n_shr;
      run_cmd(1'b0, OP_SHR, 6'd3, '0, 5'd0, 1'b1, lat, rid, rerr, rd, rsout);
      tests++; if (lat !== 2) begin fails++; $display("FAIL shr0_lat got %0d want 2", lat); end
      tests++; if (rsout !== 1'b0) begin fails++; $display("FAIL shr0_sout got %b want 0", rsout); end
      tests++; if (n_shr - s0 !== 0) begin fails++; $display("FAIL shr0_strobes got %0d want 0", n_shr - s0); end
      run_cmd(1'b0, OP_READ, 6'd3, '0, '0, 1'b0, lat, rid, rerr, rd, rsout);
      tests++; if (rd !== 32'h0000_0005) begin fails++; $display("FAIL shr0_result got %h want 00000005", rd); end
   endtask

   task automatic test_errors();
      int lat, s0, f0; logic rid, rerr, rsout; logic [DATA_W-1:0] rd;
      s0 = n_load + n_shl + n_shr + n_flush + n_oe;
      run_cmd(1'b0, 3'd6, 6'd0, 32'hDEAD_BEEF, 5'd3, 1'b1, lat, rid, rerr, rd, rsout);
      tests++; if (lat !== 2) begin fails++; $display("FAIL op6_lat got %0d want 2", lat); end
      tests++; if (rerr !== 1'b1) begin fails++; $display("FAIL op6_err got %b want 1", rerr); end
      run_cmd(1'b0, OP_READ, 6'd40, '0, '0, 1'b0, lat, rid, rerr, rd, rsout);
      tests++; if (lat !== 2) begin fails++; $display("FAIL sel40_lat got %0d want 2", lat); end
      tests++; if (rerr !== 1'b1) begin fails++; $display("FAIL sel40_err got %b want 1", rerr); end
      tests++; if (rd !== 32'h0) begin fails++; $display("FAIL sel40_data got %h want 0", rd); end
      tests++; if (n_load + n_shl + n_shr + n_flush + n_oe - s0 !== 0) begin
         fails++; $display("FAIL err_strobes got %0d want 0", n_load + n_shl + n_shr + n_flush + n_oe - s0); end
      f0 = n_flush;
      run_cmd(1'b1, OP_FLUSH, 6'd40, '0, '0, 1'b0, lat, rid, rerr, rd, rsout);
      tests++; if (rerr !== 1'b0) begin fails++; $display("FAIL flush_err got %b want 0", rerr); end
      tests++; if (lat !== 2) begin fails++; $display("FAIL flush_lat got %0d want 2", lat); end
      tests++; if (n_flush - f0 !== 1) begin fails++; $display("FAIL flush_strobes got %0d want 1", n_flush - f0); end
      run_cmd(1'b0, OP_READ, 6'd0, '0, '0, 1'b0, lat, rid, rerr, rd, rsout);
      tests++; if (rd !== 32'h0) begin fails++; $display("FAIL flush_result got %h want 0", rd); end
   endtask

   task automatic test_reset_mid();
      int nshr = 0, rsp0; bit acc = 0, hit = 0, got = 0; logic first_b = 1'bx;
      @(negedge clk);
      set_req(1'b0, OP_SHR, 6'd3, '0, 5'd10, 1'b0);
      bus.a_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (bus.a_ready) acc = 1;
         if (bus.bank_shift_right) nshr++;
         if (nshr == 3) begin
            rst_n = 1'b0;
            #1;
            hit = 1;
            tests++; if (bus.bank_shift_right !== 1'b0) begin fails++; $display("FAIL mid_shr_drop got %b want 0", bus.bank_shift_right); end
            tests++; if ({bus.bank_sel, bus.bank_oe, bus.rsp_valid} !== '0) begin
               fails++; $display("FAIL mid_outputs got sel=%0d oe=%b rsp=%b want 0", bus.bank_sel, bus.bank_oe, bus.rsp_valid); end
            break;
         end
         @(negedge clk);
         if (acc) bus.a_valid = 1'b0;
      end
      bus.a_valid = 1'b0;
      tests++; if (hit !== 1'b1) begin fails++; $display("FAIL mid_third_strobe got %0d strobes want 3", nshr); end
      rsp0 = n_rsp;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      tests++; if (n_rsp !== rsp0) begin fails++; $display("FAIL mid_no_rsp got %0d want 0", n_rsp - rsp0); end
      set_req(1'b0, OP_LOAD, 6'd4, 32'h1, '0, 1'b0);
      set_req(1'b1, OP_LOAD, 6'd5, 32'h2, '0, 1'b0);
      bus.a_valid = 1'b1; bus.b_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (bus.a_ready || bus.b_ready) begin first_b = bus.b_ready; got = 1; break; end
         @(negedge clk);
      end
      @(negedge clk);
      bus.a_valid = 1'b0; bus.b_valid = 1'b0;
      repeat (4) @(negedge clk);
      tests++; if (got !== 1'b1 || first_b !== 1'b0) begin fails++; $display("FAIL mid_next_grant got b=%b granted=%b want A", first_b, got); end
   endtask

   initial begin
      bus.a_valid = 1'b0; bus.b_valid = 1'b0;
      set_req(1'b0, OP_LOAD, '0, '0, '0, 1'b0);
      set_req(1'b1, OP_LOAD, '0, '0, '0, 1'b0);
      rst_n = 1'b0;
      test_reset();
      test_round_robin();
      test_load_read();
      test_shift();
      test_shift_zero();
      test_errors();
      test_reset_mid();
      tests++; if (n_multi !== 0) begin fails++; $display("FAIL multi_strobe got %0d want 0", n_multi); end
      tests++; if (n_lr !== 0) begin fails++; $display("FAIL shl_shr_overlap got %0d want 0", n_lr); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
